uart_word_loader: RTL and testbench
===================================

UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 7: number of 32-bit instruction words per load session.
REQ-002 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: idle clk cycles after which a partial word is discarded.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge; the only clock in the block.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port io_data_valid, input, 1: one-cycle strobe from the UART receiver.
REQ-007 SHALL have port io_data_packet, input, 8: received byte; valid only while io_data_valid=1.
REQ-008 SHALL have port load_enable, input, 1: level signal; 1 arms and holds a load session.
REQ-009 SHALL have port imem_we, output, 1: one-cycle instruction-memory write strobe.
REQ-010 SHALL have port imem_addr, output, ADDR_W: word address for the write.
REQ-011 SHALL have port imem_wdata, output, 32: assembled instruction word.
REQ-012 SHALL have port load_done, output, 1: high once NUM_WORDS words have been written.
REQ-013 SHALL have port timeout_err, output, 1: sticky flag; a partial word was discarded.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-015 IDLE -> COLLECT when load_enable=1; byte index, word address and timeout counter are cleared to 0 on entry.
REQ-016 In COLLECT, each io_data_valid pulse SHALL shift io_data_packet in; first byte -> bits [31:24], fourth byte -> bits [7:0] (MSB-first).
REQ-017 On the fourth byte, FSM SHALL go to WRITE; imem_we=1 for exactly one cycle, the cycle after that byte's valid, with imem_wdata = the assembled word and imem_addr = the current word address.
REQ-018 In the WRITE cycle, an io_data_valid byte SHALL be captured as byte 0 of the next word; no byte is lost.
REQ-019 After WRITE, the word address SHALL increment by 1; if NUM_WORDS words have been written, go to DONE, else go to COLLECT.
REQ-020 In DONE, load_done=1 and all io_data_valid pulses are ignored; DONE -> IDLE when load_enable=0.
REQ-021 load_enable=0 while in COLLECT or WRITE SHALL abort: a pending WRITE completes, then the FSM goes to IDLE and the partial word is dropped; no timeout_err is raised.
REQ-022 Timeout counter SHALL run only in COLLECT with byte index != 0 and reset on every accepted byte; on reaching TIMEOUT_CYCLES-1 the byte index clears, timeout_err sets, and the word address is unchanged.
REQ-023 timeout_err SHALL clear only on reset or on the IDLE -> COLLECT transition.
REQ-024 The word address SHALL wrap modulo 2^ADDR_W if NUM_WORDS > 2^ADDR_W; no error is flagged.
REQ-025 io_data_valid in IDLE SHALL be ignored.

Reset
REQ-026 On reset=1, asynchronously: state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, timeout_err=0; internal counters and shift register = 0.
REQ-027 Reset asserted mid-session SHALL abandon the session with no further imem_we pulse; a new session requires load_enable=1 after reset release.

Structure
REQ-028 FSM state enum and the BYTES_PER_WORD=4 constant SHALL reside in shared package loader_pkg.
REQ-029 Byte-assembly shift register plus byte index SHALL be sub-module byte_to_word_packer; FSM, address and timeout logic stay in the top module.

Verification
REQ-030 load_enable=1; 28 bytes 00 A0 00 93 01 40 01 13 00 20 81 B3 40 11 82 33 00 22 42 B3 08 00 03 13 00 53 20 23 at UART spacing -> 7 writes: addr0=0x00A00093, addr1=0x01400113, addr2=0x002081B3, addr3=0x40118233, addr4=0x002242B3, addr5=0x08000313, addr6=0x00532023; load_done=1.
REQ-031 Back-to-back io_data_valid every cycle, bytes 11 22 33 44 55 66 77 88 -> 0x11223344 @0 and 0x55667788 @1; no byte lost.
REQ-032 Send 2 bytes AA BB, then stay idle for TIMEOUT_CYCLES (set to 100) -> timeout_err=1, no write; next 4 bytes DE AD BE EF -> 0xDEADBEEF @0.
REQ-033 After load_done, send 4 more bytes -> no imem_we; drop load_enable, then raise it -> load_done=0, next word written @0.
REQ-034 Assert reset after 3 bytes of word 2 -> all outputs 0 immediately, no write; re-run REQ-030 -> identical result.
REQ-035 load_enable=0 after 2 bytes -> FSM returns to IDLE, no write, timeout_err stays 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-word loader.
package loader_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/byte_to_word_packer.sv
// MSB-first byte-to-word shift register with byte index; one byte per cycle, no stall.
// word_next/last are combinational views of the word that the current byte completes.
module byte_to_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        last,
  output logic        empty
);

  logic [31:0]           shreg;
  logic [BYTE_IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (shift) begin
      shreg <= word_next;
      // Index wraps to 0 after the last byte, so the next byte starts a fresh word.
      idx   <= idx + BYTE_IDX_W'(1);
    end
  end

  assign word_next = {shreg[23:0], data};
  assign last      = (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign empty     = (idx == '0);

endmodule

// File: rtl/uart_word_loader.sv
// Assembles UART bytes into 32-bit words and writes NUM_WORDS of them to instruction memory.
// Write strobe follows the completing byte by one cycle; no backpressure, partial words time out.
module uart_word_loader
  import loader_pkg::*;
#(
  parameter int NUM_WORDS      = 7,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_data_valid,
  input  logic [7:0]        io_data_packet,
  input  logic              load_enable,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              timeout_err
);

  localparam int TC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WC_W = $clog2(NUM_WORDS + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [WC_W-1:0]   wcount;
  logic [TC_W-1:0]   tcnt;

  logic        accept;
  logic        clear;
  logic        timeout_hit;
  logic [31:0] word_next;
  logic        last;
  logic        empty;

  // Bytes are taken in WRITE as well, so a back-to-back stream never loses one.
  assign accept      = io_data_valid && ((state == COLLECT) || (state == WRITE));
  assign timeout_hit = (state == COLLECT) && load_enable && !io_data_valid && !empty &&
                       (tcnt == TC_W'(TIMEOUT_CYCLES - 1));
  assign clear       = ((state == IDLE) && load_enable) || timeout_hit;

  byte_to_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift     (accept),
    .data      (io_data_packet),
    .word_next (word_next),
    .last      (last),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      wcount      <= '0;
      tcnt        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      load_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          imem_we <= 1'b0;
          if (load_enable) begin
            state       <= COLLECT;
            addr        <= '0;
            wcount      <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
          end
        end
        COLLECT: begin
          if (!load_enable) begin
            state <= IDLE;
          end else if (io_data_valid) begin
            tcnt <= '0;
            if (last) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_wdata <= word_next;
              imem_addr  <= addr;
            end
          end else if (!empty) begin
            if (timeout_hit) begin
              tcnt        <= '0;
              timeout_err <= 1'b1;
            end else begin
              tcnt <= tcnt + TC_W'(1);
            end
          end
        end
        WRITE: begin
          imem_we <= 1'b0;
          addr    <= addr + ADDR_W'(1);
          wcount  <= wcount + WC_W'(1);
          tcnt    <= '0;
          if (!load_enable) begin
            state <= IDLE;
          end else if (wcount == WC_W'(NUM_WORDS - 1)) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            state <= COLLECT;
          end
        end
        DONE: begin
          if (!load_enable) begin
            state     <= IDLE;
            load_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_uart_word_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_data_valid;
  logic [7:0]  io_data_packet;
  logic        load_enable;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        load_done;
  logic        timeout_err;

  uart_word_loader #(
    .NUM_WORDS      (7),
    .ADDR_W         (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_data_valid  (io_data_valid),
    .io_data_packet (io_data_packet),
    .load_enable    (load_enable),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .load_done      (load_done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  logic [7:0] prog_bytes [28] = '{
    8'h00, 8'hA0, 8'h00, 8'h93, 8'h01, 8'h40, 8'h01, 8'h13,
    8'h00, 8'h20, 8'h81, 8'hB3, 8'h40, 8'h11, 8'h82, 8'h33,
    8'h00, 8'h22, 8'h42, 8'hB3, 8'h08, 8'h00, 8'h03, 8'h13,
    8'h00, 8'h53, 8'h20, 8'h23};
  logic [31:0] prog_words [7] = '{
    32'h00A00093, 32'h01400113, 32'h002081B3, 32'h40118233,
    32'h002242B3, 32'h08000313, 32'h00532023};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %0h data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("write_addr", {56'd0, imem_addr}, {56'd0, e.a});
        check("write_data", {32'd0, imem_wdata}, {32'd0, e.d});
      end
    end
  end

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Called and returns at posedge+1; gap idle cycles follow the byte.
  task automatic send(input logic [7:0] b, input int gap);
    io_data_valid  = 1'b1;
    io_data_packet = b;
    @(posedge clk); #1;
    io_data_valid  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!load_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("load_done_set", {63'd0, load_done}, 64'd1);
  endtask

  task automatic run_full();
    cycles(2);
    for (int i = 0; i < 7; i++) expect_write(8'(i), prog_words[i]);
    for (int i = 0; i < 28; i++) send(prog_bytes[i], 9);
    wait_done(50);
    check("program_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    io_data_valid  = 1'b0;
    io_data_packet = 8'h00;
    load_enable    = 1'b0;
    cycles(3);
    check("rst_we",    {63'd0, imem_we},     64'd0);
    check("rst_addr",  {56'd0, imem_addr},   64'd0);
    check("rst_wdata", {32'd0, imem_wdata},  64'd0);
    check("rst_done",  {63'd0, load_done},   64'd0);
    check("rst_tout",  {63'd0, timeout_err}, 64'd0);
    reset = 1'b0;
    cycles(2);

    // Bytes while idle must be ignored.
    send(8'h55, 1);
    send(8'h66, 1);

    // Full 7-word program.
    load_enable = 1'b1;
    run_full();

    // Bytes after completion are ignored; re-arm restarts at address 0.
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 3);
    load_enable = 1'b0;
    cycles(2);
    check("done_cleared", {63'd0, load_done}, 64'd0);
    load_enable = 1'b1;
    cycles(2);
    expect_write(8'h00, 32'h12345678);
    send(8'h12, 4); send(8'h34, 4); send(8'h56, 4); send(8'h78, 4);
    check("rearm_drained", 64'(sb.size()), 64'd0);
    load_enable = 1'b0;
    cycles(3);

    // Back-to-back bytes, including one landing in the write cycle.
    load_enable = 1'b1;
    cycles(2);
    expect_write(8'h00, 32'h11223344);
    expect_write(8'h01, 32'h55667788);
    for (int i = 0; i < 8; i++) send(8'h11 * 8'(i + 1), 0);
    cycles(3);
    check("b2b_drained", 64'(sb.size()), 64'd0);
    load_enable = 1'b0;
    cycles(3);

    // Partial word times out; next word still lands at address 0.
    load_enable = 1'b1;
    cycles(2);
    send(8'hAA, 1);
    send(8'hBB, 110);
    check("timeout_set", {63'd0, timeout_err}, 64'd1);
    expect_write(8'h00, 32'hDEADBEEF);
    send(8'hDE, 3); send(8'hAD, 3); send(8'hBE, 3); send(8'hEF, 3);
    check("timeout_drained", 64'(sb.size()), 64'd0);
    check("timeout_sticky", {63'd0, timeout_err}, 64'd1);
    load_enable = 1'b0;
    cycles(3);

    // Abort mid-word: no write, and the new session cleared the sticky flag.
    load_enable = 1'b1;
    cycles(2);
    check("tout_cleared", {63'd0, timeout_err}, 64'd0);
    send(8'h01, 2);
    send(8'h02, 2);
    load_enable = 1'b0;
    cycles(150);
    check("abort_no_tout", {63'd0, timeout_err}, 64'd0);

    // Reset during word 2 of a session, then a clean rerun.
    load_enable = 1'b1;
    cycles(2);
    expect_write(8'h00, prog_words[0]);
    expect_write(8'h01, prog_words[1]);
    for (int i = 0; i < 11; i++) send(prog_bytes[i], 4);
    reset = 1'b1;
    #1;
    check("mid_rst_we",    {63'd0, imem_we},     64'd0);
    check("mid_rst_addr",  {56'd0, imem_addr},   64'd0);
    check("mid_rst_wdata", {32'd0, imem_wdata},  64'd0);
    check("mid_rst_done",  {63'd0, load_done},   64'd0);
    check("mid_rst_tout",  {63'd0, timeout_err}, 64'd0);
    check("pre_rst_drained", 64'(sb.size()), 64'd0);
    cycles(3);
    reset = 1'b0;
    run_full();

    cycles(5);
    check("final_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
